// File: rtl/display_scan_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_counter_pkg
//  Description : Shared constants, types and helpers for the four-digit
//                multiplexed BCD display counter.
//                Contents:
//                  NUM_DIGITS  - number of decades / display digits
//                  BCD_MAX     - largest legal decimal digit value
//                  digit_idx_t - scan index type (selects one digit)
//                  AN_RESET    - anode pattern selecting digit 0
//                  an_select() - active-low one-hot anode pattern for an index
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scan_counter_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] AN_RESET   = 4'b1110;
  localparam logic [3:0] AN_BLANK   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot enable: a single 0 at the selected digit position.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_counter_bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : One decimal decade (0..9) with ripple carry.
//                Ports:
//                  clk   - system clock, rising edge
//                  rst   - synchronous active-high reset, forces 0
//                  clr   - synchronous clear, forces 0 (below rst)
//                  cin   - carry in; advances the decade by one
//                  digit - current BCD value, never above 9
//                  cout  - carry out; high when cin is high and digit is 9
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
  import display_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  // Carry is combinational so a full chain of nines rolls over on one edge.
  assign cout = cin && (digit == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (cin) begin
      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_counter
//  Description : Four-digit BCD event counter driving a multiplexed
//                7-segment display (BCD code to an external decoder).
//                Ports:
//                  CLK  - system clock, rising edge
//                  RST  - synchronous active-high reset
//                  INC  - count enable, +1 per edge
//                  CLR  - synchronous clear of the count
//                  LZB  - leading-zero blanking enable
//                  A..D - BCD code of the displayed digit, A = MSB
//                  AN   - active-low one-hot digit enables, AN[0] = digit 0
//                  OVF  - one-cycle pulse after the 9999 -> 0000 wrap
//                Parameter:
//                  REFRESH_DIV - clock cycles per digit slot (2..65535)
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_counter
  import display_scan_counter_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
)
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       INC,
  input  logic       CLR,
  input  logic       LZB,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [3:0] AN,
  output logic       OVF
);

  localparam int                   PRESC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  // --------------------------------------------------------------------------
  // Decade chain. carry[0] is the count enable; carry[NUM_DIGITS] is the wrap.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS:0]        carry;

  assign carry[0] = INC;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_decade
      bcd_digit_counter u_decade (
        .clk   (CLK),
        .rst   (RST),
        .clr   (CLR),
        .cin   (carry[k]),
        .digit (digits[k]),
        .cout  (carry[k+1])
      );
    end
  endgenerate

  // Wrap pulse: clear wins over a simultaneous increment at 9999.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF <= 1'b0;
    end else begin
      OVF <= carry[NUM_DIGITS] && !CLR;
    end
  end

  // --------------------------------------------------------------------------
  // Scan timing: prescaler terminal value is the tick that moves the index.
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc;
  digit_idx_t         idx;
  logic               scan_tick;

  assign scan_tick = (presc == PRESC_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
    end else if (scan_tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection: lead_zero[k] is set when digit k and every digit
  // above it are zero. Digit 0 is excluded from blanking by the index test.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run && (digits[k] == 4'd0);
      lead_zero[k] = run;
    end
  end

  logic       blank;
  logic [3:0] sel_digit;

  assign blank     = LZB && (idx != 2'd0) && lead_zero[idx];
  assign sel_digit = digits[idx];

  // --------------------------------------------------------------------------
  // Registered display outputs. Enables and code share one register stage so
  // they switch on the same edge, one cycle after the index moves. The live
  // count and LZB are sampled every cycle, so mid-slot changes show at once.
  // --------------------------------------------------------------------------
  logic [3:0] code;

  always_ff @(posedge CLK) begin
    if (RST) begin
      AN   <= AN_RESET;
      code <= 4'd0;
    end else if (blank) begin
      AN   <= AN_BLANK;
      code <= 4'd0;
    end else begin
      AN   <= an_select(idx);
      code <= sel_digit;
    end
  end

  assign {A, B, C, D} = code;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_counter
//  Description : Self-checking bench for display_scan_counter. A decimal
//                model (integer count, cycle counter since reset) predicts
//                AN, BCD code and OVF for every cycle; literal checks pin
//                the model on the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       clr = 1'b0;
  logic       lzb = 1'b0;
  logic       a, b, c, d;
  logic [3:0] an;
  logic       ovf;

  display_scan_counter #(.REFRESH_DIV(DIV)) dut (
    .CLK (clk),
    .RST (rst),
    .INC (inc),
    .CLR (clr),
    .LZB (lzb),
    .A   (a),
    .B   (b),
    .C   (c),
    .D   (d),
    .AN  (an),
    .OVF (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: decimal count and number of edges since the last reset.
  int         cnt = 0;
  int         n   = 0;
  bit         valid = 1'b0;
  logic [3:0] exp_an   = 4'b1110;
  logic [3:0] exp_abcd = 4'b0000;
  logic       exp_ovf  = 1'b0;

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Display rule: the digit shown after an edge is the one the scan position
  // selected before it (position = edges since reset / DIV, mod 4), taken
  // from the count as it was before that edge.
  task automatic model_edge(input bit r, input bit i, input bit cl, input bit lz);
    int idx;
    int above;
    if (r) begin
      cnt      = 0;
      n        = 0;
      exp_an   = 4'b1110;
      exp_abcd = 4'b0000;
      exp_ovf  = 1'b0;
      valid    = 1'b1;
    end else if (valid) begin
      idx   = (n / DIV) % 4;
      above = cnt / pow10(idx);
      if (lz && idx != 0 && above == 0) begin
        exp_an   = 4'b1111;
        exp_abcd = 4'b0000;
      end else begin
        exp_an   = ~(4'b0001 << idx);
        exp_abcd = 4'(above % 10);
      end
      if (cl) begin
        cnt     = 0;
        exp_ovf = 1'b0;
      end else if (i) begin
        exp_ovf = (cnt == 9999);
        cnt     = (cnt + 1) % 10000;
      end else begin
        exp_ovf = 1'b0;
      end
      n++;
    end
  endtask

  task automatic step(input bit r, input bit i, input bit cl, input bit lz);
    @(negedge clk);
    rst = r;
    inc = i;
    clr = cl;
    lzb = lz;
    @(posedge clk);
    #1;
    model_edge(r, i, cl, lz);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (valid) begin
      chk("AN", an, exp_an);
      chk("ABCD", {a, b, c, d}, exp_abcd);
      chk("OVF", {3'b000, ovf}, {3'b000, exp_ovf});
    end
  end

  // Tally a full 16-cycle scan period with the count held.
  task automatic scan_tally(input bit lz, output int t0, output int t1, output int t2,
                            output int t3, output int tbl, output int tnz);
    t0 = 0; t1 = 0; t2 = 0; t3 = 0; tbl = 0; tnz = 0;
    repeat (4 * DIV) begin
      step(1'b0, 1'b0, 1'b0, lz);
      case ({an, a, b, c, d})
        8'b1110_0010: t0++;
        8'b1101_0001: t1++;
        8'b1011_0000: t2++;
        8'b0111_0000: t3++;
        8'b1111_0000: tbl++;
        default: ;
      endcase
      if ({a, b, c, d} != 4'd0) tnz++;
    end
  endtask

  int  t0, t1, t2, t3, tbl, tnz;
  int  bad;
  int  slot_len;
  bit  lz_rand;

  initial begin
    // Reset held two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset AN", an, 4'b1110);
    chk("reset ABCD", {a, b, c, d}, 4'b0000);
    chk("reset OVF", {3'b000, ovf}, 4'b0000);

    // Count to 0012, then one scan period without blanking.
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0);
    scan_tally(1'b0, t0, t1, t2, t3, tbl, tnz);
    chk_int("slot0 1110/0010", t0, 4);
    chk_int("slot1 1101/0001", t1, 4);
    chk_int("slot2 1011/0000", t2, 4);
    chk_int("slot3 0111/0000", t3, 4);

    // Same count with leading-zero blanking.
    scan_tally(1'b1, t0, t1, t2, t3, tbl, tnz);
    chk_int("lzb slot0", t0, 4);
    chk_int("lzb slot1", t1, 4);
    chk_int("lzb blanked", tbl, 8);

    // Clear and increment together at 0457.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (457) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr OVF", {3'b000, ovf}, 4'b0000);
    scan_tally(1'b0, t0, t1, t2, t3, tbl, tnz);
    chk_int("clr nonzero digits", tnz, 0);

    // Run to 9999, then wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bad = 0;
    repeat (9999) begin
      lz_rand = 1'($urandom % 2);
      step(1'b0, 1'b1, 1'b0, lz_rand);
      if ({a, b, c, d} > 4'd9) bad++;
    end
    chk("pre-wrap OVF", {3'b000, ovf}, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap OVF", {3'b000, ovf}, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-wrap OVF", {3'b000, ovf}, 4'b0000);
    chk_int("illegal digits seen", bad, 0);
    scan_tally(1'b0, t0, t1, t2, t3, tbl, tnz);
    chk_int("wrapped nonzero digits", tnz, 0);

    // Reset in the middle of digit 2's slot.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2 * DIV + 1) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid slot2 AN", an, 4'b1011);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart AN", an, 4'b1110);
    // Index sits on digit 0 for DIV cycles; the display follows one edge later.
    slot_len = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (an != 4'b1110) begin
        slot_len = k;
        break;
      end
    end
    chk_int("first slot after reset", slot_len, DIV + 1);

    // Randomized traffic.
    lz_rand = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) lz_rand = ~lz_rand;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           lz_rand);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
